// File: rtl/oled_spi_rx.sv
// rtl/oled_spi_rx.sv - SSD1306-style OLED SPI receiver producing framebuffer writes and display-control state
module oled_spi_rx #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       oled_clk,
    input  logic       oled_data,
    input  logic       oled_dc,
    output logic       fb_wr,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       frame_done,
    output logic       display_on,
    output logic [7:0] contrast,
    output logic       invert,
    output logic       seg_remap,
    output logic       com_flip
);

    localparam int IW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARG_LAST  = 2'd1,
        ST_ARG_FIRST = 2'd2
    } cmd_state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   spi_edge;

    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [IW-1:0] idle_cnt;
    logic          byte_valid;
    logic [7:0]    byte_reg;
    logic          byte_dc;

    cmd_state_t    state;
    cmd_state_t    state_next;
    logic [1:0]    cmd_nargs;
    logic [7:0]    pend_cmd;

    logic [1:0]    mode;
    logic [6:0]    col;
    logic [6:0]    col_start;
    logic [6:0]    col_end;
    logic [2:0]    page;
    logic [2:0]    page_start;
    logic [2:0]    page_end;

    assign spi_edge = clk_sync[SYNC_STAGES-1] & ~clk_prev;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync   <= '0;
            dc_sync    <= '0;
            data_sync  <= '0;
            clk_prev   <= 1'b0;
            shreg      <= 8'd0;
            bit_cnt    <= 3'd0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            byte_reg   <= 8'd0;
            byte_dc    <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], oled_clk};
            dc_sync    <= {dc_sync[SYNC_STAGES-2:0], oled_dc};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], oled_data};
            clk_prev   <= clk_sync[SYNC_STAGES-1];
            byte_valid <= spi_edge && (bit_cnt == 3'd7);
            if (spi_edge) begin
                shreg    <= {shreg[6:0], data_sync[SYNC_STAGES-1]};
                bit_cnt  <= bit_cnt + 3'd1;
                idle_cnt <= '0;
                if (bit_cnt == 3'd7) begin
                    byte_reg <= {shreg[6:0], data_sync[SYNC_STAGES-1]};
                    byte_dc  <= dc_sync[SYNC_STAGES-1];
                end
            end else if (idle_cnt == IDLE_MAX) begin
                // Realign to a byte boundary after a stalled transfer
                shreg    <= 8'd0;
                bit_cnt  <= 3'd0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        cmd_nargs  = 2'd0;
        state_next = state;
        case (byte_reg)
            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB:         cmd_nargs = 2'd1;
            8'h21, 8'h22:                       cmd_nargs = 2'd2;
            default:                            cmd_nargs = 2'd0;
        endcase
        if (byte_valid) begin
            if (byte_dc) begin
                state_next = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:      state_next = (cmd_nargs == 2'd2) ? ST_ARG_FIRST :
                                               (cmd_nargs == 2'd1) ? ST_ARG_LAST : ST_IDLE;
                    ST_ARG_FIRST: state_next = ST_ARG_LAST;
                    default:      state_next = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            fb_wr      <= 1'b0;
            fb_addr    <= 10'd0;
            fb_data    <= 8'd0;
            frame_done <= 1'b0;
            display_on <= 1'b0;
            contrast   <= 8'h7F;
            invert     <= 1'b0;
            seg_remap  <= 1'b0;
            com_flip   <= 1'b0;
            pend_cmd   <= 8'd0;
            mode       <= 2'd2;
            col        <= 7'd0;
            col_start  <= 7'd0;
            col_end    <= 7'd127;
            page       <= 3'd0;
            page_start <= 3'd0;
            page_end   <= 3'd7;
        end else begin
            fb_wr      <= 1'b0;
            frame_done <= 1'b0;
            if (byte_valid && byte_dc) begin
                fb_wr      <= 1'b1;
                fb_addr    <= {page, col};
                fb_data    <= byte_reg;
                frame_done <= (mode != 2'd2) && (col == col_end) && (page == page_end);
                case (mode)
                    2'd0: begin
                        if (col == col_end) begin
                            col  <= col_start;
                            page <= (page == page_end) ? page_start : page + 3'd1;
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                    2'd1: begin
                        if (page == page_end) begin
                            page <= page_start;
                            col  <= (col == col_end) ? col_start : col + 7'd1;
                        end else begin
                            page <= page + 3'd1;
                        end
                    end
                    default: col <= (col == col_end) ? col_start : col + 7'd1;
                endcase
            end else if (byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        pend_cmd <= byte_reg;
                        casez (byte_reg)
                            8'hAE:       display_on <= 1'b0;
                            8'hAF:       display_on <= 1'b1;
                            8'hA6:       invert     <= 1'b0;
                            8'hA7:       invert     <= 1'b1;
                            8'hA0:       seg_remap  <= 1'b0;
                            8'hA1:       seg_remap  <= 1'b1;
                            8'hC0:       com_flip   <= 1'b0;
                            8'hC8:       com_flip   <= 1'b1;
                            8'b1011_0???: page      <= byte_reg[2:0];
                            8'b0000_????: col[3:0]  <= byte_reg[3:0];
                            8'b0001_0???: col[6:4]  <= byte_reg[2:0];
                            default: ;
                        endcase
                    end
                    ST_ARG_FIRST: begin
                        if (pend_cmd == 8'h21) col_start  <= byte_reg[6:0];
                        if (pend_cmd == 8'h22) page_start <= byte_reg[2:0];
                    end
                    default: begin
                        case (pend_cmd)
                            8'h20: mode <= (byte_reg[1:0] == 2'd3) ? 2'd2 : byte_reg[1:0];
                            8'h21: begin
                                col_end <= byte_reg[6:0];
                                col     <= col_start;
                            end
                            8'h22: begin
                                page_end <= byte_reg[2:0];
                                page     <= page_start;
                            end
                            8'h81: contrast <= byte_reg;
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_rx.sv
// tb/tb_oled_spi_rx.sv - scoreboard bench for oled_spi_rx
module tb_oled_spi_rx;

    logic       clk_74a = 1'b0;
    logic       reset_n = 1'b0;
    logic       oled_clk = 1'b0;
    logic       oled_data = 1'b0;
    logic       oled_dc = 1'b0;
    logic       fb_wr;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       frame_done;
    logic       display_on;
    logic [7:0] contrast;
    logic       invert;
    logic       seg_remap;
    logic       com_flip;

    oled_spi_rx #(.SYNC_STAGES(2), .IDLE_TIMEOUT(1024)) dut (
        .clk_74a(clk_74a), .reset_n(reset_n), .oled_clk(oled_clk),
        .oled_data(oled_data), .oled_dc(oled_dc), .fb_wr(fb_wr),
        .fb_addr(fb_addr), .fb_data(fb_data), .frame_done(frame_done),
        .display_on(display_on), .contrast(contrast), .invert(invert),
        .seg_remap(seg_remap), .com_flip(com_flip)
    );

    always #5 clk_74a = ~clk_74a;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rise_cyc = 0;

    always @(posedge clk_74a) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bits are launched 2ns after a clock edge: 3 cycles low, 3 cycles high
    task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            oled_data = b[i];
            oled_dc   = dc;
            repeat (3) @(posedge clk_74a);
            #2;
            oled_clk = 1'b1;
            rise_cyc = cyc;
            repeat (3) @(posedge clk_74a);
            #2;
            oled_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        send_bits(dc, b, 8);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(1'b0, b);
    endtask

    task automatic data(input logic [9:0] addr, input logic [7:0] b, input logic fd);
        sb.push_back('{addr: addr, data: b, fd: fd});
        send_byte(1'b1, b);
    endtask

    always @(negedge clk_74a) begin
        if (fb_wr) begin
            if (sb.size() == 0) begin
                check("unexpected_wr", {22'd0, fb_addr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("fb_addr", {22'd0, fb_addr}, {22'd0, e.addr});
                check("fb_data", {24'd0, fb_data}, {24'd0, e.data});
                check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
                // rise seen by bench -> 2 sync stages -> edge + 2 cycles
                check("latency", cyc - rise_cyc, 4);
            end
        end else if (frame_done) begin
            check("fd_without_wr", 1, 0);
        end
    end

    task automatic check_ctrl(input string tag, input logic on, input logic [7:0] con,
                              input logic inv, input logic rem, input logic flip);
        check({tag, "_display_on"}, {31'd0, display_on}, {31'd0, on});
        check({tag, "_contrast"}, {24'd0, contrast}, {24'd0, con});
        check({tag, "_invert"}, {31'd0, invert}, {31'd0, inv});
        check({tag, "_seg_remap"}, {31'd0, seg_remap}, {31'd0, rem});
        check({tag, "_com_flip"}, {31'd0, com_flip}, {31'd0, flip});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (4) @(posedge clk_74a);
        #2;
        check("rst_fb_wr", {31'd0, fb_wr}, 0);
        check("rst_fb_addr", {22'd0, fb_addr}, 0);
        check("rst_fb_data", {24'd0, fb_data}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check_ctrl("rst", 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_74a);
        #2;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk_74a);
            waited++;
        end
        #2;
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        do_reset();

        // full-screen horizontal fill
        cmd(8'h20); cmd(8'h00);
        cmd(8'h21); cmd(8'h00); cmd(8'h7F);
        cmd(8'h22); cmd(8'h00); cmd(8'h07);
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] a;
            a = i[9:0];
            data(a, a[7:0], i == 1023);
        end
        drain();

        // horizontal mode, small window
        cmd(8'h21); cmd(8'd10); cmd(8'd12);
        cmd(8'h22); cmd(8'd2);  cmd(8'd3);
        data(10'd266, 8'h01, 1'b0);
        data(10'd267, 8'h02, 1'b0);
        data(10'd268, 8'h03, 1'b0);
        data(10'd394, 8'h04, 1'b0);
        data(10'd395, 8'h05, 1'b0);
        data(10'd396, 8'h06, 1'b1);
        data(10'd266, 8'h07, 1'b0);
        drain();

        // vertical mode
        cmd(8'h20); cmd(8'h01);
        cmd(8'h21); cmd(8'd0); cmd(8'd1);
        cmd(8'h22); cmd(8'd0); cmd(8'd1);
        data(10'd0,   8'hC1, 1'b0);
        data(10'd128, 8'hC2, 1'b0);
        data(10'd1,   8'hC3, 1'b0);
        data(10'd129, 8'hC4, 1'b1);
        data(10'd0,   8'hC5, 1'b0);
        drain();

        // page mode direct addressing after reset
        do_reset();
        cmd(8'hB3); cmd(8'h05); cmd(8'h12);
        data(10'd421, 8'hAA, 1'b0);
        drain();

        // display-control commands
        cmd(8'hAF); cmd(8'h81); cmd(8'h40); cmd(8'hA7); cmd(8'hA1); cmd(8'hC8);
        cmd(8'hD5); cmd(8'hAF);
        repeat (4) @(posedge clk_74a);
        #2;
        check_ctrl("ctl_on", 1'b1, 8'h40, 1'b1, 1'b1, 1'b1);
        cmd(8'hAE); cmd(8'hD5); cmd(8'hAF); cmd(8'hA6); cmd(8'hA0); cmd(8'hC0);
        repeat (4) @(posedge clk_74a);
        #2;
        check_ctrl("ctl_off", 1'b0, 8'h40, 1'b0, 1'b0, 1'b0);

        // data byte abandons a pending 0x81
        cmd(8'h81);
        data(10'd422, 8'h33, 1'b0);
        drain();
        check("abandon_contrast", {24'd0, contrast}, 32'h40);

        // partial byte then idle timeout realigns
        send_bits(1'b1, 8'hE0, 3);
        repeat (1100) @(posedge clk_74a);
        #2;
        data(10'd423, 8'h5A, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
